// File: rtl/latch_write_sequencer.sv
// ============================================================================
// latch_write_sequencer
//
// Purpose:
//   Shares one WIDTH-bit transparent D-latch bank among NREQ requesters.
//   A round-robin arbiter picks one writer. The latch is then driven through
//   SETUP -> OPEN -> HOLD so that latch_d is stable before latch_en rises and
//   stays stable after latch_en falls. This block is the only driver of the
//   latch bank's d/en inputs.
//
// Ports:
//   clk      in   1           clock, rising edge
//   rst      in   1           asynchronous reset, active-high
//   req      in   NREQ        write request per requester, held until done
//   wdata    in   NREQ*WIDTH  write data, requester i owns [i*WIDTH +: WIDTH]
//   gnt      out  NREQ        one-hot grant, high for the whole transaction
//   done     out  1           one-cycle pulse at transaction end
//   busy     out  1           high while the sequencer is not idle
//   latch_d  out  WIDTH       data to the latch bank
//   latch_en out  1           latch enable (transparent when high)
//   latch_q  in   WIDTH       latch output, read back only with the check
//   err      out  1           sticky readback mismatch flag
//
// Configuration macro:
//   LATCH_SEQ_CHECK_EN - when defined, latch_q is compared with latch_d in
//   the last HOLD cycle and err is set on a mismatch (cleared only by rst).
//   When undefined, latch_q is ignored and err stays 0.
// ============================================================================
module latch_write_sequencer #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  busy,
    output logic [WIDTH-1:0]      latch_d,
    output logic                  latch_en,
    input  logic [WIDTH-1:0]      latch_q,
    output logic                  err
);

    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAX_A = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = (MAX_C > 0) ? $clog2(MAX_C + 1) : 1;

    // Counter reload values: a phase lasts (load + 1) cycles, ending at 0.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [IW-1:0]   gidx_reg;

    // Per-requester data slices.
    logic [WIDTH-1:0] slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: first set req searching upward from rr_ptr, wrapping.
    // The loop runs from the farthest offset down so the nearest one wins.
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   pos;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pos        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_reg} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(NREQ)) begin
                pos = pos - (IW + 1)'(NREQ);
            end
            if (req[pos[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = pos[IW-1:0];
            end
        end
    end

    logic [IW-1:0] rr_next;
    assign rr_next = (gidx_reg == IW'(NREQ - 1)) ? '0 : gidx_reg + 1'b1;

    // Readback comparison is only meaningful in the last HOLD cycle.
`ifdef LATCH_SEQ_CHECK_EN
    logic q_mismatch;
    assign q_mismatch = (latch_q != latch_d);
`else
    logic unused_latch_q;
    assign unused_latch_q = ^latch_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
            gidx_reg   <= '0;
            gnt        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            latch_d    <= '0;
            latch_en   <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg <= SETUP;
                        cnt_reg   <= SETUP_LOAD;
                        gidx_reg  <= pick_idx;
                        gnt       <= NREQ'(1) << pick_idx;
                        latch_d   <= slice[pick_idx];
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= OPEN;
                        cnt_reg   <= OPEN_LOAD;
                        latch_en  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                OPEN: begin
                    if (cnt_reg == '0) begin
                        state_reg <= HOLD;
                        cnt_reg   <= HOLD_LOAD;
                        latch_en  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= IDLE;
                        gnt        <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        rr_ptr_reg <= rr_next;
`ifdef LATCH_SEQ_CHECK_EN
                        if (q_mismatch) begin
                            err <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// ============================================================================
// tb_latch_write_sequencer
//
// Directed, table-driven bench for latch_write_sequencer with defaults
// NREQ=4, WIDTH=8, SETUP/OPEN/HOLD = 1/2/1. A behavioural latch bank models
// latch_q; it can be forced to 0 to exercise the readback check.
// ============================================================================
module tb_latch_write_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic [7:0]  latch_d;
    logic        latch_en;
    logic [7:0]  latch_q;
    logic        err;

    logic [7:0]  bank = '0;
    logic        force_zero = 1'b0;

    int checks = 0;
    int passes = 0;

`ifdef LATCH_SEQ_CHECK_EN
    localparam logic ERR_ON_BAD = 1'b1;
`else
    localparam logic ERR_ON_BAD = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural transparent latch bank.
    always_latch begin
        if (latch_en) bank = latch_d;
    end
    assign latch_q = force_zero ? 8'h00 : bank;

    latch_write_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .latch_d  (latch_d),
        .latch_en (latch_en),
        .latch_q  (latch_q),
        .err      (err)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits for a grant (bounded), then walks the transaction cycle by cycle.
    // Returns at the done cycle (state back in IDLE).
    task automatic do_txn(input logic [3:0] eg, input logic [7:0] ed,
                          input bit drop, input bit chk_q, input int ew);
        int w;
        w = 0;
        do begin
            tick();
            w++;
        end while (gnt == '0 && w < 8);
        chk("grant_wait", w, ew);
        chk("gnt", {28'd0, gnt}, {28'd0, eg});
        chk("latch_d_setup", {24'd0, latch_d}, {24'd0, ed});
        chk("en_setup", {31'd0, latch_en}, 32'd0);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("done_setup", {31'd0, done}, 32'd0);
        wdata = ~wdata;                       // must not reach latch_d
        tick();
        chk("en_open1", {31'd0, latch_en}, 32'd1);
        if (drop) req = '0;
        tick();
        chk("en_open2", {31'd0, latch_en}, 32'd1);
        chk("gnt_open", {28'd0, gnt}, {28'd0, eg});
        tick();
        chk("en_hold", {31'd0, latch_en}, 32'd0);
        chk("done_hold", {31'd0, done}, 32'd0);
        chk("latch_d_hold", {24'd0, latch_d}, {24'd0, ed});
        tick();
        chk("done", {31'd0, done}, 32'd1);
        chk("gnt_end", {28'd0, gnt}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("en_end", {31'd0, latch_en}, 32'd0);
        chk("latch_d_kept", {24'd0, latch_d}, {24'd0, ed});
        if (chk_q) chk("latch_q", {24'd0, latch_q}, {24'd0, ed});
    endtask

    initial begin
        vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 8'hA5};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
        vecs[2] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
        vecs[3] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
        vecs[4] = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
        vecs[5] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
        vecs[6] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
        vecs[7] = '{4'b0001, 32'h000000C7, 4'b0001, 8'hC7};
        vecs[8] = '{4'b1010, 32'hDEADBEEF, 4'b0010, 8'hBE};
        vecs[9] = '{4'b1010, 32'hDEADBEEF, 4'b1000, 8'hDE};

        // Reset state
        tick();
        tick();
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, latch_en}, 32'd0);
        chk("rst_d", {24'd0, latch_d}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Table: single write, round-robin under full load, repeat, wrap.
        for (int i = 0; i < 10; i++) begin
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            do_txn(vecs[i].exp_gnt, vecs[i].exp_d, 1'b0, 1'b1, 1);
            $display("txn %0d: req=%b gnt=%b latch_d=%h", i, vecs[i].req, vecs[i].exp_gnt, latch_d);
        end
        req = '0;
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_gnt", {28'd0, gnt}, 32'd0);

        // req dropped during OPEN: transaction still completes (rr_ptr = 0 here)
        req   = 4'b0010;
        wdata = 32'h00005A00;
        do_txn(4'b0010, 8'h5A, 1'b1, 1'b1, 1);
        $display("txn drop: gnt=0010 latch_d=%h done=%b", latch_d, done);

        // rst during OPEN: outputs clear at once, no done, rr_ptr back to 0
        req   = 4'b0100;
        wdata = 32'h00770000;
        tick();
        chk("rst_seq_gnt", {28'd0, gnt}, 32'h4);
        tick();
        chk("rst_seq_en", {31'd0, latch_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_en", {31'd0, latch_en}, 32'd0);
        chk("async_gnt", {28'd0, gnt}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_d", {24'd0, latch_d}, 32'd0);
        tick();
        chk("abort_no_done", {31'd0, done}, 32'd0);
        rst   = 1'b0;
        req   = 4'b1001;
        wdata = 32'h99000066;
        do_txn(4'b0001, 8'h66, 1'b0, 1'b1, 1);
        $display("txn post-rst: gnt=0001 latch_d=%h", latch_d);

        // Readback check: bad latch output, then a good write
        force_zero = 1'b1;
        req   = 4'b0100;
        wdata = 32'h003C0000;
        do_txn(4'b0100, 8'h3C, 1'b0, 1'b0, 1);
        chk("err_set", {31'd0, err}, {31'd0, ERR_ON_BAD});
        $display("txn bad readback: latch_d=%h err=%b", latch_d, err);
        force_zero = 1'b0;
        req   = 4'b1000;
        wdata = 32'h81000000;
        do_txn(4'b1000, 8'h81, 1'b0, 1'b1, 1);
        chk("err_sticky", {31'd0, err}, {31'd0, ERR_ON_BAD});
        $display("txn good readback: latch_d=%h err=%b", latch_d, err);
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("err_cleared", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
